scroll_ctrl: RTL
================

# scroll_ctrl

Frame-rate scroll and end-of-level sequencer for the side-scrolling playfield. Advances the world scroll offset `process` consumed by the castle hit-test and the other sprite/background hit-tests, clamps it at the level end, and detects the player reaching the castle. It then runs the end-of-level sequence: forced walk-in, hide player, level done. Sits between the player motion logic and the draw-path hit-test blocks.

## Interface
- `CASTLE_X`, 10'd900: castle left edge, world coordinates.
- `DOOR_OFFSET`, 10'd24: door position relative to `CASTLE_X`.
- `FLAG_X`, 10'd840: world x that triggers the forced walk.
- `MAX_PROCESS`, 10'd384: largest scroll offset (level width 1024 − screen 640).
- `ENTER_FRAMES`, 8'd60: frames the player stays hidden before done.
- `Clk` input 1: system clock.
- `Reset` input 1: synchronous, active-high.
- `frame_clk` input 1: vertical-sync-rate frame clock, asynchronous to `Clk`.
- `player_x` input 10: player left edge, screen coordinates.
- `player_right` input 1: player moving right this frame.
- `player_speed` input 4: horizontal speed, pixels/frame.
- `restart` input 1: one-`Clk` pulse; honoured only in DONE.
- `process` output 10: world scroll offset.
- `auto_walk` output 1: forces the player right at its current speed.
- `freeze_input` output 1: motion logic ignores the keyboard.
- `hide_player` output 1: suppress player sprite.
- `level_done` output 1: level complete, held.
- `state` output 2: current FSM state, for debug.

## Operation
- Frame tick: `frame_clk` passes through a 2-flop synchroniser and a rising-edge detect, giving a single-`Clk` `tick`. All scroll and FSM updates happen only on `tick` cycles, except `restart` and `Reset`.
- World x: `wx = {1'b0,player_x} + {1'b0,process}`, 11-bit; there is no wrap.
- Scroll rule, applied on tick in PLAY and AUTOWALK:
  - Condition: `player_x > 10'd320` and (`player_right` or `auto_walk`).
  - Action: `process <= min(process + player_speed, MAX_PROCESS)`.
  - The sum is computed in 11 bits before the clamp.
- FSM, encoded PLAY=0, AUTOWALK=1, ENTER=2, DONE=3:
  - PLAY: on tick, if `wx >= FLAG_X`, go to AUTOWALK.
  - AUTOWALK: `auto_walk`=1, `freeze_input`=1. On tick, if `wx >= CASTLE_X + DOOR_OFFSET` (11-bit compare), go to ENTER and load the frame counter with `ENTER_FRAMES`.
  - ENTER: `hide_player`=1, `freeze_input`=1. Counter decrements on tick. On a tick with counter==1, go to DONE. `ENTER_FRAMES`=0 is treated as 1.
  - DONE: `level_done`=1, `hide_player`=1, `freeze_input`=1, `process` frozen. `restart` returns to PLAY with `process`=0 and all flags cleared.
- `restart` outside DONE is ignored.
- `restart` and `tick` in the same DONE cycle: `restart` wins.
- Scroll and state transition on the same tick: both take effect. The threshold compare uses pre-update `process`.

## Timing
- Reset values: `process`=0, `state`=PLAY, and `auto_walk`, `freeze_input`, `hide_player`, `level_done` all 0. Synchroniser flops also clear to 0.
- `Reset` mid-sequence returns to PLAY on the next `Clk` edge, with no residual counter.
- `frame_clk` rise to `tick`: 3 `Clk` cycles.
- `tick` to updated `process`/`state`: registered, visible the cycle after `tick`.
- All outputs are registered; flags derive from registered state.
- `process` is stable for the whole frame between ticks.

## Configuration
- `SCROLL_BACK_EN` defined:
  - Condition: on tick in PLAY, `player_x < 10'd64` and not `player_right`.
  - Action: `process <= (process > player_speed) ? process − player_speed : 0`.
- `SCROLL_BACK_EN` undefined: `process` is monotonic non-decreasing between restarts.

## Structure
- Package `level_pkg`:
  - typedef `scroll_state_t` (PLAY, AUTOWALK, ENTER, DONE).
  - Constants `SCREEN_W`=640, `SCROLL_LINE`=320, `BACK_LINE`=64.
- Sub-module `frame_tick_gen` (ports `Clk`, `Reset`, `frame_clk`, `tick`): synchroniser plus edge detect.

## Test plan
- Reset, then 5 ticks with `player_x`=330, `player_right`=1, speed 4 -> `process`=20; `state`=PLAY.
- Set `process`=382, tick with speed 4 and scroll condition true -> `process`=384 (clamped). Next tick still 384.
- `player_x`=460, `process`=384 (`wx`=844), tick -> AUTOWALK, `auto_walk`=1, `freeze_input`=1. Raise `player_x` to 540 (`wx`=924), tick -> ENTER, `hide_player`=1.
- `ENTER_FRAMES`=3 -> exactly 3 ticks in ENTER, then `level_done`=1. `restart` coincident with a tick -> PLAY, `process`=0, all flags 0.
- `Reset` asserted while in ENTER with counter=2 -> next cycle PLAY, all outputs at reset values.
- With `SCROLL_BACK_EN`: `process`=10, `player_x`=40, `player_right`=0, speed 4: tick -> 6, tick -> 2, tick -> 0. Without the macro: `process` stays 10.

Source files
------------

// File: rtl/level_pkg.sv
// level_pkg: shared types, constants and small arithmetic helpers for the
// scroll / end-of-level sequencer.
// Contents: scroll_state_t FSM encoding, screen geometry constants, and
// saturating scroll-offset helpers used by scroll_ctrl.
package level_pkg;

  // FSM encoding is visible on the debug `state` port, so keep it fixed.
  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    AUTOWALK = 2'd1,
    ENTER    = 2'd2,
    DONE     = 2'd3
  } scroll_state_t;

  localparam logic [10:0] LEVEL_W     = 11'd1024;
  localparam logic [9:0]  SCREEN_W    = 10'd640;
  localparam logic [9:0]  SCROLL_LINE = 10'd320;
  localparam logic [9:0]  BACK_LINE   = 10'd64;

  // Player is far enough right on screen that the world should move instead.
  function automatic logic in_scroll_zone(input logic [9:0] x);
    in_scroll_zone = (x > SCROLL_LINE);
  endfunction

  // Player is close enough to the left edge to pull the world back.
  function automatic logic in_back_zone(input logic [9:0] x);
    in_back_zone = (x < BACK_LINE);
  endfunction

  // Forward scroll: the sum is formed in 11 bits so an offset near the limit
  // plus a large speed cannot wrap before the clamp sees it.
  function automatic logic [9:0] clamp_add(input logic [9:0] base,
                                           input logic [3:0] step,
                                           input logic [9:0] limit);
    logic [10:0] sum;
    sum = {1'b0, base} + {7'd0, step};
    if (sum > {1'b0, limit}) begin
      clamp_add = limit;
    end else begin
      clamp_add = sum[9:0];
    end
  endfunction

  // Backward scroll: floors at zero.
  function automatic logic [9:0] floor_sub(input logic [9:0] base,
                                           input logic [3:0] step);
    if (base > {6'd0, step}) begin
      floor_sub = base - {6'd0, step};
    end else begin
      floor_sub = 10'd0;
    end
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: brings the asynchronous frame clock into the Clk domain and
// turns each rising edge into a single-Clk pulse.
// Ports: Clk, Reset (sync, active-high), frame_clk (async in), tick (out).
// Latency: frame_clk rise to tick high is 3 Clk edges (2 sync flops + a
// registered edge detect), so tick itself is glitch-free.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic tick_q;
  logic tick_d;

  // Rising edge seen on the synchronised copy.
  assign tick_d = sync2_q & ~prev_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/scroll_ctrl.sv
// scroll_ctrl: frame-rate world scroll offset and end-of-level sequencer
// (PLAY -> AUTOWALK -> ENTER -> DONE, restart back to PLAY).
// Ports: Clk, Reset (sync, active-high), frame_clk (async frame clock),
//   player_x/player_right/player_speed (motion inputs), restart (pulse);
//   outputs process (scroll offset), auto_walk, freeze_input, hide_player,
//   level_done and state (debug). All outputs are registered.
// Build option: define SCROLL_BACK_EN to let the player pull the world back
//   near the left edge while in PLAY; without it process never decreases
//   between restarts.
module scroll_ctrl
  import level_pkg::*;
#(
  parameter logic [9:0] CASTLE_X     = 10'd900,
  parameter logic [9:0] DOOR_OFFSET  = 10'd24,
  parameter logic [9:0] FLAG_X       = 10'd840,
  parameter logic [9:0] MAX_PROCESS  = 10'(LEVEL_W - {1'b0, SCREEN_W}),
  parameter logic [7:0] ENTER_FRAMES = 8'd60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] player_x,
  input  logic       player_right,
  input  logic [3:0] player_speed,
  input  logic       restart,
  output logic [9:0] process,
  output logic       auto_walk,
  output logic       freeze_input,
  output logic       hide_player,
  output logic       level_done,
  output logic [1:0] state
);

  // Door threshold compared in 11 bits so CASTLE_X + DOOR_OFFSET never wraps.
  localparam logic [10:0] DOOR_X = {1'b0, CASTLE_X} + {1'b0, DOOR_OFFSET};
  // A zero frame count would never reach the exit condition; use 1 instead.
  localparam logic [7:0] ENTER_LOAD = (ENTER_FRAMES == 8'd0) ? 8'd1 : ENTER_FRAMES;

  logic tick;

  scroll_state_t state_q, state_d;
  logic [9:0]    process_q, process_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          auto_walk_q, auto_walk_d;
  logic          freeze_q, freeze_d;
  logic          hide_q, hide_d;
  logic          done_q, done_d;

  logic [10:0]   wx;
  logic          fwd_scroll;

  frame_tick_gen u_frame_tick_gen (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  // World x uses the offset as it stands before this tick's scroll update.
  assign wx = {1'b0, player_x} + {1'b0, process_q};

  // During the forced walk the player is pushed right regardless of input.
  assign fwd_scroll = in_scroll_zone(player_x) && (player_right || auto_walk_q);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= PLAY;
      process_q   <= 10'd0;
      cnt_q       <= 8'd0;
      auto_walk_q <= 1'b0;
      freeze_q    <= 1'b0;
      hide_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      process_q   <= process_d;
      cnt_q       <= cnt_d;
      auto_walk_q <= auto_walk_d;
      freeze_q    <= freeze_d;
      hide_q      <= hide_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic (state, scroll offset, ENTER frame counter)
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    process_d = process_q;
    cnt_d     = cnt_q;

    // restart is not tick-gated and takes priority over a coincident tick.
    if ((state_q == DONE) && restart) begin
      state_d   = PLAY;
      process_d = 10'd0;
      cnt_d     = 8'd0;
    end else if (tick) begin
      unique case (state_q)
        PLAY: begin
          if (fwd_scroll) begin
            process_d = clamp_add(process_q, player_speed, MAX_PROCESS);
          end
`ifdef SCROLL_BACK_EN
          else if (in_back_zone(player_x) && !player_right) begin
            process_d = floor_sub(process_q, player_speed);
          end
`endif
          if (wx >= {1'b0, FLAG_X}) begin
            state_d = AUTOWALK;
          end
        end
        AUTOWALK: begin
          if (fwd_scroll) begin
            process_d = clamp_add(process_q, player_speed, MAX_PROCESS);
          end
          if (wx >= DOOR_X) begin
            state_d = ENTER;
            cnt_d   = ENTER_LOAD;
          end
        end
        ENTER: begin
          // <= rather than == so a corrupted zero count still exits.
          if (cnt_q <= 8'd1) begin
            state_d = DONE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        DONE: begin
          state_d = DONE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output decode: flags follow the next state so they register together
  // with it and never lag the state by a cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    auto_walk_d = 1'b0;
    freeze_d    = 1'b0;
    hide_d      = 1'b0;
    done_d      = 1'b0;
    unique case (state_d)
      PLAY: begin
        freeze_d = 1'b0;
      end
      AUTOWALK: begin
        auto_walk_d = 1'b1;
        freeze_d    = 1'b1;
      end
      ENTER: begin
        hide_d   = 1'b1;
        freeze_d = 1'b1;
      end
      DONE: begin
        hide_d   = 1'b1;
        freeze_d = 1'b1;
        done_d   = 1'b1;
      end
    endcase
  end

  assign process      = process_q;
  assign auto_walk    = auto_walk_q;
  assign freeze_input = freeze_q;
  assign hide_player  = hide_q;
  assign level_done   = done_q;
  assign state        = state_q;

endmodule
